// File: rtl/pfc3ph_reg_arbiter_if.sv
// AXI4-Lite register bus between the two-requester arbiter and the pfc3ph_inter S00_AXI port.
interface pfc3ph_reg_arbiter_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/pfc3ph_reg_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite register port between boot sequencer (0) and host (1).
// Optional response watchdog with drain state: define PFC3PH_ARB_TIMEOUT_EN.
module pfc3ph_reg_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [1:0]        ack,
    output logic [31:0]       rdata,
    output logic [1:0]        resp,
    output logic              timeout_flag,
    pfc3ph_reg_arbiter_if.master m_axi
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
`ifdef PFC3PH_ARB_TIMEOUT_EN
    localparam logic [2:0] DRAIN   = 3'd6;
`endif

    logic [2:0]        state_reg;
    logic              last_grant_reg;
    logic              grant_reg;
    logic              grant_next;
    logic              we_reg;
    logic [ADDR_W-1:0] awaddr_reg;
    logic [ADDR_W-1:0] araddr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        resp_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        grant_onehot;
    logic              awvalid_reg;
    logic              wvalid_reg;
    logic              bready_reg;
    logic              arvalid_reg;
    logic              rready_reg;

    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_we;
    logic              aw_pend_next;
    logic              w_pend_next;
    logic              ar_hs;
    logic              b_hs;
    logic              r_hs;
    logic              phase_done;

    // On a tie the requester that was not granted last wins; otherwise the lone requester wins.
    always_comb begin
        grant_next = 1'b0;
        if (req[0] && req[1]) begin
            grant_next = ~last_grant_reg;
        end else if (req[1]) begin
            grant_next = 1'b1;
        end
    end

    assign sel_addr  = grant_next ? addr1  : addr0;
    assign sel_wdata = grant_next ? wdata1 : wdata0;
    assign sel_we    = we[grant_next];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_reg == 1'(gi));
        end
    endgenerate

    // A VALID stays pending only while the slave has not accepted it.
    assign aw_pend_next = awvalid_reg & ~m_axi.M_AXI_AWREADY;
    assign w_pend_next  = wvalid_reg  & ~m_axi.M_AXI_WREADY;
    assign ar_hs        = arvalid_reg &  m_axi.M_AXI_ARREADY;
    assign b_hs         = bready_reg  &  m_axi.M_AXI_BVALID;
    assign r_hs         = rready_reg  &  m_axi.M_AXI_RVALID;

    always_comb begin
        phase_done = 1'b0;
        case (state_reg)
            WR_ADDR: phase_done = !aw_pend_next && !w_pend_next;
            WR_RESP: phase_done = b_hs;
            RD_ADDR: phase_done = ar_hs;
            RD_RESP: phase_done = r_hs;
            default: phase_done = 1'b0;
        endcase
    end

`ifdef PFC3PH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             busy;
    logic             tmo_hit;
    logic             timeout_flag_reg;

    assign busy    = (state_reg == WR_ADDR) || (state_reg == WR_RESP) ||
                     (state_reg == RD_ADDR) || (state_reg == RD_RESP);
    // A phase that completes in its last allowed cycle is not treated as a timeout.
    assign tmo_hit = busy && !phase_done && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_reg <= '0;
        end else if (busy && !phase_done && !tmo_hit) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else begin
            cnt_reg <= '0;
        end
    end

    assign timeout_flag = timeout_flag_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_flag   = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            we_reg         <= 1'b0;
            awaddr_reg     <= '0;
            araddr_reg     <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            resp_reg       <= 2'b00;
            ack_reg        <= 2'b00;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
`ifdef PFC3PH_ARB_TIMEOUT_EN
            timeout_flag_reg <= 1'b0;
`endif
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        we_reg         <= sel_we;
                        if (sel_we) begin
                            awaddr_reg  <= sel_addr;
                            wdata_reg   <= sel_wdata;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WR_ADDR;
                        end else begin
                            araddr_reg  <= sel_addr;
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    awvalid_reg <= aw_pend_next;
                    wvalid_reg  <= w_pend_next;
                    if (phase_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (phase_done) begin
                        bready_reg <= 1'b0;
                        resp_reg   <= m_axi.M_AXI_BRESP;
                        rdata_reg  <= '0;
                        ack_reg    <= grant_onehot;
                        state_reg  <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (phase_done) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (phase_done) begin
                        rready_reg <= 1'b0;
                        resp_reg   <= m_axi.M_AXI_RRESP;
                        rdata_reg  <= m_axi.M_AXI_RDATA;
                        ack_reg    <= grant_onehot;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
`ifdef PFC3PH_ARB_TIMEOUT_EN
                // Finish the abandoned bus transaction silently so the slave is never left mid-handshake.
                DRAIN: begin
                    if (we_reg) begin
                        awvalid_reg <= aw_pend_next;
                        wvalid_reg  <= w_pend_next;
                        if (bready_reg) begin
                            if (b_hs) begin
                                bready_reg <= 1'b0;
                                state_reg  <= IDLE;
                            end
                        end else if (!aw_pend_next && !w_pend_next) begin
                            bready_reg <= 1'b1;
                        end
                    end else begin
                        if (rready_reg) begin
                            if (r_hs) begin
                                rready_reg <= 1'b0;
                                state_reg  <= IDLE;
                            end
                        end else if (!arvalid_reg || ar_hs) begin
                            arvalid_reg <= 1'b0;
                            rready_reg  <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
`ifdef PFC3PH_ARB_TIMEOUT_EN
            if (tmo_hit) begin
                ack_reg          <= grant_onehot;
                resp_reg         <= 2'b11;
                rdata_reg        <= '0;
                timeout_flag_reg <= 1'b1;
                state_reg        <= DRAIN;
            end
`endif
        end
    end

    assign ack   = ack_reg;
    assign rdata = rdata_reg;
    assign resp  = resp_reg;

    assign m_axi.M_AXI_AWADDR  = awaddr_reg;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_reg;
    assign m_axi.M_AXI_WDATA   = wdata_reg;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = wvalid_reg;
    assign m_axi.M_AXI_BREADY  = bready_reg;
    assign m_axi.M_AXI_ARADDR  = araddr_reg;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_reg;
    assign m_axi.M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_pfc3ph_reg_arbiter.sv
// Directed bench for pfc3ph_reg_arbiter with a delay-programmable 4-register AXI4-Lite slave.
module tb_pfc3ph_reg_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [3:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;

    pfc3ph_reg_arbiter_if #(.ADDR_W(4)) axi ();

    pfc3ph_reg_arbiter #(.ADDR_W(4), .TIMEOUT(TMO)) dut (
        .ACLK(clk), .ARESET(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .resp(resp), .timeout_flag(timeout_flag),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    // Slave model: each ready/valid appears after a programmable number of waiting cycles.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit slv_err = 1'b0;
    logic [31:0] regs [4];
    logic aw_got, w_got, ar_got;
    logic [3:0] aw_a, ar_a;
    logic [31:0] w_d;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int b_hs_cnt = 0;

    assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && !aw_got && (aw_wait >= aw_dly);
    assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && !w_got && (w_wait >= w_dly);
    assign axi.M_AXI_BVALID  = aw_got && w_got && (b_wait >= b_dly);
    assign axi.M_AXI_BRESP   = slv_err ? 2'b10 : 2'b00;
    assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && !ar_got && (ar_wait >= ar_dly);
    assign axi.M_AXI_RVALID  = ar_got && (r_wait >= r_dly);
    assign axi.M_AXI_RDATA   = regs[ar_a[3:2]];
    assign axi.M_AXI_RRESP   = slv_err ? 2'b10 : 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
        end else begin
            if (axi.M_AXI_AWVALID && !aw_got) begin
                if (axi.M_AXI_AWREADY) begin
                    aw_got <= 1'b1; aw_a <= axi.M_AXI_AWADDR; aw_wait <= 0;
                end else aw_wait <= aw_wait + 1;
            end
            if (axi.M_AXI_WVALID && !w_got) begin
                if (axi.M_AXI_WREADY) begin
                    w_got <= 1'b1; w_d <= axi.M_AXI_WDATA; w_wait <= 0;
                end else w_wait <= w_wait + 1;
            end
            if (aw_got && w_got) begin
                if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
                    regs[aw_a[3:2]] <= w_d;
                    aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
                    b_hs_cnt <= b_hs_cnt + 1;
                end else b_wait <= b_wait + 1;
            end
            if (axi.M_AXI_ARVALID && !ar_got) begin
                if (axi.M_AXI_ARREADY) begin
                    ar_got <= 1'b1; ar_a <= axi.M_AXI_ARADDR; ar_wait <= 0;
                end else ar_wait <= ar_wait + 1;
            end
            if (ar_got) begin
                if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
                    ar_got <= 1'b0; r_wait <= 0;
                end else r_wait <= r_wait + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one transaction from requester r; returns the ack sample and cycles from req to ack.
    task automatic do_txn(input int r, input bit w, input logic [3:0] a, input logic [31:0] d,
                          output logic [1:0] g_ack, output logic [31:0] g_rd,
                          output logic [1:0] g_resp, output int lat);
        if (r == 0) begin addr0 = a; wdata0 = d; end
        else begin addr1 = a; wdata1 = d; end
        we[r]  = w;
        req[r] = 1'b1;
        g_ack = 2'b00; g_rd = '0; g_resp = 2'b00; lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) begin
                g_ack = ack; g_rd = rdata; g_resp = resp; lat = c;
                break;
            end
        end
        req[r] = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", {30'd0, ack}, 32'd0);
    endtask

    typedef struct {
        int          rq;
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        bit          err;
        logic [1:0]  e_ack;
        logic [31:0] e_rd;
        logic [1:0]  e_resp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1:0]  g_ack, g_resp, got;
        logic [31:0] g_rd;
        int          lat, b0, ack_cnt;
        bit          seen;

        for (int i = 0; i < 4; i++) begin
            vecs[i].rq = 0; vecs[i].wr = 1'b1; vecs[i].a = 4'(i * 4); vecs[i].d = 32'(i + 1);
            vecs[i].err = 1'b0; vecs[i].e_ack = 2'b01; vecs[i].e_rd = 32'd0; vecs[i].e_resp = 2'b00;
            vecs[i+4].rq = 1; vecs[i+4].wr = 1'b0; vecs[i+4].a = 4'(i * 4); vecs[i+4].d = 32'd0;
            vecs[i+4].err = 1'b0; vecs[i+4].e_ack = 2'b10; vecs[i+4].e_rd = 32'(i + 1); vecs[i+4].e_resp = 2'b00;
        end
        vecs[8] = '{rq: 1, wr: 1'b1, a: 4'hC, d: 32'h55, err: 1'b1, e_ack: 2'b10, e_rd: 32'd0, e_resp: 2'b10};
        vecs[9] = '{rq: 0, wr: 1'b0, a: 4'hC, d: 32'h0, err: 1'b1, e_ack: 2'b01, e_rd: 32'h55, e_resp: 2'b10};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {30'd0, resp}, 32'd0);
        check("rst_tflag", {31'd0, timeout_flag}, 32'd0);
        check("rst_valids", {28'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID, 1'b0}, 32'd0);
        check("rst_readys", {30'd0, axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 32'd0);
        check("rst_addr", {24'd0, axi.M_AXI_AWADDR, axi.M_AXI_ARADDR}, 32'd0);
        check("rst_wdata", axi.M_AXI_WDATA, 32'd0);
        check("tie_prot_strb", {22'd0, axi.M_AXI_AWPROT, axi.M_AXI_ARPROT, axi.M_AXI_WSTRB}, {22'd0, 6'd0, 4'hF});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            slv_err = vecs[i].err;
            do_txn(vecs[i].rq, vecs[i].wr, vecs[i].a, vecs[i].d, g_ack, g_rd, g_resp, lat);
            $display("txn %0d: req%0d %s addr=0x%h ack=%b rdata=0x%08h resp=%b lat=%0d",
                     i, vecs[i].rq, vecs[i].wr ? "WR" : "RD", vecs[i].a, g_ack, g_rd, g_resp, lat);
            check($sformatf("vec%0d_ack", i), {30'd0, g_ack}, {30'd0, vecs[i].e_ack});
            check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].e_rd);
            check($sformatf("vec%0d_resp", i), {30'd0, g_resp}, {30'd0, vecs[i].e_resp});
            check($sformatf("vec%0d_latency", i), lat, 32'd3);
        end
        slv_err = 1'b0;

        // Round robin after a fresh reset: both requesters write continuously.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        we = 2'b11; addr0 = 4'h0; wdata0 = 32'hA0; addr1 = 4'h4; wdata1 = 32'hB1; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 2'b00;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                if (ack != 2'b00) begin got = ack; break; end
            end
            $display("rr grant %0d: ack=%b resp=%b", k, got, resp);
            check($sformatf("rr%0d_ack", k), {30'd0, got}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_resp", k), {30'd0, resp}, 32'd0);
        end
        req = 2'b00; we = 2'b00;
        @(posedge clk); #1;
        do_txn(1, 1'b0, 4'h0, 32'h0, g_ack, g_rd, g_resp, lat);
        $display("txn rr_rd0: ack=%b rdata=0x%08h resp=%b", g_ack, g_rd, g_resp);
        check("rr_rd0_data", g_rd, 32'hA0);
        do_txn(0, 1'b0, 4'h4, 32'h0, g_ack, g_rd, g_resp, lat);
        $display("txn rr_rd4: ack=%b rdata=0x%08h resp=%b", g_ack, g_rd, g_resp);
        check("rr_rd4_data", g_rd, 32'hB1);

        // WREADY lags AWREADY by three cycles.
        aw_dly = 0; w_dly = 3; b0 = b_hs_cnt;
        addr0 = 4'hC; wdata0 = 32'hCC; we[0] = 1'b1; req[0] = 1'b1;
        @(posedge clk); #1;
        check("skew_c1_aw_w", {30'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, 32'd3);
        @(posedge clk); #1;
        check("skew_c2_aw_w", {30'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, 32'd1);
        @(posedge clk); #1; @(posedge clk); #1;
        check("skew_c4_aw_w", {30'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, 32'd1);
        got = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) begin got = ack; break; end
        end
        $display("txn skew: ack=%b resp=%b", got, resp);
        check("skew_ack", {30'd0, got}, 32'd1);
        req[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("skew_one_b", b_hs_cnt - b0, 32'd1);
        w_dly = 0;

        // Reset while the read is waiting for R.
        r_dly = 10; addr1 = 4'h8; we[1] = 1'b0; req[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (axi.M_AXI_RREADY) begin seen = 1'b1; break; end
        end
        check("rstmid_in_rresp", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_ar_r", {30'd0, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 32'd0);
        req[1] = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rst = 1'b0;
            @(posedge clk); #1;
            if (ack != 2'b00) ack_cnt++;
        end
        check("rstmid_no_ack", ack_cnt, 32'd0);
        r_dly = 0;
        do_txn(1, 1'b0, 4'h8, 32'h0, g_ack, g_rd, g_resp, lat);
        $display("txn post_rst_rd8: ack=%b rdata=0x%08h resp=%b lat=%0d", g_ack, g_rd, g_resp, lat);
        check("postrst_ack", {30'd0, g_ack}, 32'd2);
        check("postrst_rdata", g_rd, 32'd3);
        check("postrst_lat", lat, 32'd3);
        do_txn(0, 1'b0, 4'hC, 32'h0, g_ack, g_rd, g_resp, lat);
        $display("txn rd_c: ack=%b rdata=0x%08h resp=%b", g_ack, g_rd, g_resp);
        check("skew_data_landed", g_rd, 32'hCC);

`ifdef PFC3PH_ARB_TIMEOUT_EN
        // B withheld for 40 cycles: watchdog acks with 2'b11, then the late B is drained.
        b_dly = 40; b0 = b_hs_cnt;
        do_txn(0, 1'b1, 4'h0, 32'h77, g_ack, g_rd, g_resp, lat);
        $display("txn tmo: ack=%b rdata=0x%08h resp=%b lat=%0d", g_ack, g_rd, g_resp, lat);
        check("tmo_ack", {30'd0, g_ack}, 32'd1);
        check("tmo_resp", {30'd0, g_resp}, 32'd3);
        check("tmo_rdata", g_rd, 32'd0);
        check("tmo_lat", lat, 32'(TMO + 2));
        check("tmo_flag", {31'd0, timeout_flag}, 32'd1);
        check("tmo_drain_bready", {31'd0, axi.M_AXI_BREADY}, 32'd1);
        ack_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (b_hs_cnt != b0) break;
            @(posedge clk); #1;
            if (ack != 2'b00) ack_cnt++;
        end
        check("tmo_late_b", b_hs_cnt - b0, 32'd1);
        check("tmo_drain_no_ack", ack_cnt, 32'd0);
        b_dly = 0;
        do_txn(1, 1'b1, 4'h4, 32'h99, g_ack, g_rd, g_resp, lat);
        $display("txn post_tmo: ack=%b resp=%b lat=%0d", g_ack, g_resp, lat);
        check("posttmo_ack", {30'd0, g_ack}, 32'd2);
        check("posttmo_resp", {30'd0, g_resp}, 32'd0);
        check("posttmo_lat", lat, 32'd3);
        check("tmo_flag_sticky", {31'd0, timeout_flag}, 32'd1);
`else
        check("tflag_tied", {31'd0, timeout_flag}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
